instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Program store and instruction issuer that sits directly upstream of the processor datapath/control pair. It holds a small loadable program, drives the 11-bit `INSTRUCTION` bus the control circuit consumes, and advances only when the control circuit pulses `Done`. For external-load instructions it presents the opcode word for one cycle, then the immediate data word from the next program location, so the immediate is on the bus while the external-load tri-state drives it. A watchdog flags a stalled control circuit.

## Interface
- `INSTR_WIDTH`, 11: width of instruction and program words.
- `ADDR_WIDTH`, 4: program address width; depth = 2^ADDR_WIDTH.
- `LD_OPC`, 3'b000: value of `INSTRUCTION[10:8]` that marks an external-load instruction.
- `TIMEOUT`, 64: maximum cycles in WAIT before error.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `prog_we`  in  1  write `prog_data` to `prog_addr` (IDLE/FINISH/ERROR only).
- `prog_addr`  in  ADDR_WIDTH  program write address.
- `prog_data`  in  INSTR_WIDTH  program write data.
- `prog_len`  in  ADDR_WIDTH+1  number of words to execute, sampled on `start`.
- `start`  in  1  begin execution at address 0.
- `Done`  in  1  one-cycle completion pulse from the control circuit.
- `INSTRUCTION`  out  INSTR_WIDTH  registered word driven to the control circuit.
- `pc`  out  ADDR_WIDTH  address of the word currently on `INSTRUCTION`.
- `busy`  out  1  high in ISSUE/WAIT.
- `finished`  out  1  one-cycle pulse when the program completes.
- `error`  out  1  sticky; timeout or truncated load.

## Operation
- Memory: 2^ADDR_WIDTH × INSTR_WIDTH register array, write-only via `prog_we`; not cleared by reset. `prog_we` ignored while `busy`.
- States: IDLE, ISSUE, WAIT, FINISH, ERROR.
- IDLE: `INSTRUCTION`=0. `start`=1 and `prog_len`≠0 → latch length, `pc`=0, `INSTRUCTION`=mem[0], → ISSUE. `start` with `prog_len`=0 → FINISH.
- ISSUE (exactly one cycle; `Done` ignored here):
  - opcode ≠ `LD_OPC` → hold word, → WAIT.
  - opcode = `LD_OPC` and `pc`+1 < length → `pc`+=1, `INSTRUCTION`=mem[`pc`+1], → WAIT.
  - opcode = `LD_OPC` and `pc`+1 = length → `INSTRUCTION`=0, `error`=1, → ERROR.
- WAIT: `INSTRUCTION` held; watchdog counts cycles from 0.
  - `Done`=1 and `pc`+1 = length → `INSTRUCTION`=0, → FINISH.
  - `Done`=1 otherwise → `pc`+=1, `INSTRUCTION`=mem[`pc`+1], → ISSUE; watchdog cleared.
  - watchdog reaches TIMEOUT−1 without `Done` → `INSTRUCTION`=0, `error`=1, → ERROR. `Done` in that same cycle wins.
- FINISH: `finished`=1 for this single cycle, → IDLE. `start` here is ignored.
- ERROR: outputs held (`INSTRUCTION`=0, `busy`=0, `error`=1) until `reset`, or until `start`, which clears `error` and behaves as in IDLE.
- `start` while `busy` ignored. `pc` never wraps: length ≤ 2^ADDR_WIDTH and execution stops at length.

## Timing
- Reset (synchronous): state IDLE, `pc`=0, `INSTRUCTION`=0, `busy`=0, `finished`=0, `error`=0, watchdog=0. Reset mid-program aborts immediately. No `finished` pulse is produced.
- `start` sampled at edge N → `INSTRUCTION`=mem[0], `busy`=1 after edge N.
- Non-load word: on the bus from ISSUE through the WAIT cycle in which `Done` is seen. The next word appears one edge after `Done`.
- Load word: opcode on the bus for exactly one cycle; the data word follows the next edge and is held until `Done`.
- Minimum per-instruction occupancy: 2 cycles (ISSUE + one WAIT cycle with `Done`).
- A write to address A in the same cycle as `start` is committed; mem[0] read after the edge reflects it.

## Test plan
- Program {0x1A5, 0x2C3}, len=2, `start`; pulse `Done` 3 cycles after each ISSUE → bus shows 0x1A5 then 0x2C3, `pc` 0→1, `finished` pulses 1 cycle after the second `Done`, then `INSTRUCTION`=0.
- Program {0x012 (load), 0x7FF, 0x300}, len=3 → bus 0x012 for exactly 1 cycle, then 0x7FF with `pc`=1 held until `Done`, then 0x300 with `pc`=2.
- Program {0x040 (load)}, len=1 → one cycle of 0x040, then `error`=1, `busy`=0, `INSTRUCTION`=0.
- Never assert `Done`, TIMEOUT=64 → `error` rises 64 cycles after entering WAIT. A subsequent `start` clears `error` and reruns from `pc`=0.
- Assert `reset` during WAIT of instruction 1, plus `start`/`prog_we` while `busy` → all outputs 0 next cycle, memory retained, ignored writes absent on readback.
- `start` with `prog_len`=0 → `finished` pulse one cycle after, `busy` never asserted.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Program-load and instruction-issue signals between the sequencer and its
// driver (program loader plus control circuit).
interface instr_sequencer_if #(
   parameter int INSTR_WIDTH = 11,
   parameter int ADDR_WIDTH  = 4
);
   logic                   prog_we;
   logic [ADDR_WIDTH-1:0]  prog_addr;
   logic [INSTR_WIDTH-1:0] prog_data;
   logic [ADDR_WIDTH:0]    prog_len;
   logic                   start;
   logic                   Done;
   logic [INSTR_WIDTH-1:0] INSTRUCTION;
   logic [ADDR_WIDTH-1:0]  pc;
   logic                   busy;
   logic                   finished;
   logic                   error;

   modport master (
      output prog_we, prog_addr, prog_data, prog_len, start, Done,
      input  INSTRUCTION, pc, busy, finished, error
   );

   modport slave (
      input  prog_we, prog_addr, prog_data, prog_len, start, Done,
      output INSTRUCTION, pc, busy, finished, error
   );
endinterface

// File: rtl/instr_sequencer.sv
// Loadable program store that issues one instruction word at a time to the
// control circuit, advancing on Done, with a watchdog for a stalled controller.
module instr_sequencer #(
   parameter int         INSTR_WIDTH = 11,
   parameter int         ADDR_WIDTH  = 4,
   parameter logic [2:0] LD_OPC      = 3'b000,
   parameter int         TIMEOUT     = 64
) (
   input logic               clk,
   input logic               reset,
   instr_sequencer_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int WD_W  = $clog2(TIMEOUT) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_FINISH = 3'd3;
   localparam logic [2:0] S_ERROR  = 3'd4;

   logic [INSTR_WIDTH-1:0] mem [DEPTH];
   logic [2:0]             state;
   logic [INSTR_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0]  pc;
   logic [ADDR_WIDTH:0]    len;
   logic [WD_W-1:0]        wdog;
   logic                   err;

   logic                   is_busy;
   logic                   is_load;
   logic                   last;
   logic [ADDR_WIDTH:0]    pc_inc;
   logic [ADDR_WIDTH-1:0]  pc_nxt;
   logic [INSTR_WIDTH-1:0] mem0;

   assign is_busy = (state == S_ISSUE) || (state == S_WAIT);
   assign pc_inc  = {1'b0, pc} + {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign pc_nxt  = pc_inc[ADDR_WIDTH-1:0];
   assign last    = (pc_inc == len);
   assign is_load = (instr[INSTR_WIDTH-1 -: 3] == LD_OPC);
   // A write to word 0 in the start cycle must be visible on the first issue.
   assign mem0    = (bus.prog_we && bus.prog_addr == '0) ? bus.prog_data : mem[0];

   always_ff @(posedge clk) begin
      if (bus.prog_we && !is_busy)
         mem[bus.prog_addr] <= bus.prog_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         instr <= '0;
         pc    <= '0;
         len   <= '0;
         wdog  <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_ERROR: begin
               if (bus.start) begin
                  err  <= 1'b0;
                  len  <= bus.prog_len;
                  pc   <= '0;
                  wdog <= '0;
                  if (bus.prog_len != '0) begin
                     instr <= mem0;
                     state <= S_ISSUE;
                  end else begin
                     instr <= '0;
                     state <= S_FINISH;
                  end
               end
            end
            S_ISSUE: begin
               wdog <= '0;
               if (!is_load) begin
                  state <= S_WAIT;
               end else if (!last) begin
                  // Load: swap the opcode for its immediate word.
                  pc    <= pc_nxt;
                  instr <= mem[pc_nxt];
                  state <= S_WAIT;
               end else begin
                  pc    <= '0;
                  instr <= '0;
                  err   <= 1'b1;
                  state <= S_ERROR;
               end
            end
            S_WAIT: begin
               if (bus.Done) begin
                  if (last) begin
                     pc    <= '0;
                     instr <= '0;
                     state <= S_FINISH;
                  end else begin
                     pc    <= pc_nxt;
                     instr <= mem[pc_nxt];
                     wdog  <= '0;
                     state <= S_ISSUE;
                  end
               end else if (wdog == WD_LAST) begin
                  pc    <= '0;
                  instr <= '0;
                  err   <= 1'b1;
                  state <= S_ERROR;
               end else begin
                  wdog <= wdog + WD_ONE;
               end
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   assign bus.INSTRUCTION = instr;
   assign bus.pc          = pc;
   assign bus.busy        = is_busy;
   assign bus.finished    = (state == S_FINISH);
   assign bus.error       = err;
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed cycle-by-cycle check of instr_sequencer: table-driven programs plus
// hand-written sequences for load error, watchdog, reset abort and empty start.
module tb_instr_sequencer;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   instr_sequencer_if #(.INSTR_WIDTH(11), .ADDR_WIDTH(4)) bus ();

   instr_sequencer #(
      .INSTR_WIDTH(11),
      .ADDR_WIDTH (4),
      .LD_OPC     (3'b000),
      .TIMEOUT    (64)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        st;
      logic        dn;
      logic        we;
      logic [3:0]  addr;
      logic [10:0] data;
      logic [4:0]  len;
      logic [10:0] e_ins;
      logic [3:0]  e_pc;
      logic        e_busy;
      logic        e_fin;
      logic        e_err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic rst, input logic st, input logic dn,
                              input logic we, input logic [3:0] addr,
                              input logic [10:0] data, input logic [4:0] len,
                              input logic [10:0] e_ins, input logic [3:0] e_pc,
                              input logic e_busy, input logic e_fin, input logic e_err);
      vec_t r;
      r.rst = rst; r.st = st; r.dn = dn; r.we = we; r.addr = addr; r.data = data;
      r.len = len; r.e_ins = e_ins; r.e_pc = e_pc; r.e_busy = e_busy;
      r.e_fin = e_fin; r.e_err = e_err;
      return r;
   endfunction

   // Drive one cycle of inputs, then check outputs 1 time unit after the edge.
   task automatic cyc(input vec_t t, input string name);
      logic [17:0] got, exp;
      @(negedge clk);
      reset         = t.rst;
      bus.start     = t.st;
      bus.Done      = t.dn;
      bus.prog_we   = t.we;
      bus.prog_addr = t.addr;
      bus.prog_data = t.data;
      bus.prog_len  = t.len;
      @(posedge clk);
      #1;
      got = {bus.INSTRUCTION, bus.pc, bus.busy, bus.finished, bus.error};
      exp = {t.e_ins, t.e_pc, t.e_busy, t.e_fin, t.e_err};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got ins=%h pc=%0d busy=%b fin=%b err=%b, want ins=%h pc=%0d busy=%b fin=%b err=%b",
                  name, bus.INSTRUCTION, bus.pc, bus.busy, bus.finished, bus.error,
                  t.e_ins, t.e_pc, t.e_busy, t.e_fin, t.e_err);
      end
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1; total = 0; bad = 0;
      bus.start = 1'b0; bus.Done = 1'b0; bus.prog_we = 1'b0;
      bus.prog_addr = '0; bus.prog_data = '0; bus.prog_len = '0;

      //              rst st dn we addr data    len   ins     pc busy fin err
      tbl.push_back(v(1, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0));
      // two plain words, Done three cycles after each issue
      tbl.push_back(v(0, 0, 0, 1, 0, 11'h1A5, 0, 11'h000, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 1, 11'h2C3, 0, 11'h000, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 0, 11'h000, 2, 11'h1A5, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h1A5, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h1A5, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h1A5, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 0, 11'h000, 0, 11'h2C3, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h2C3, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h2C3, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h2C3, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 0, 11'h000, 0, 11'h000, 0, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0));
      // load + immediate; word 0 written in the start cycle; Done in ISSUE ignored
      tbl.push_back(v(0, 0, 0, 1, 1, 11'h7FF, 0, 11'h000, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 2, 11'h300, 0, 11'h000, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 1, 0, 11'h012, 3, 11'h012, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 0, 11'h000, 0, 11'h7FF, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h7FF, 1, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 0, 11'h000, 0, 11'h300, 2, 1, 0, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h300, 2, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 0, 11'h000, 0, 11'h000, 0, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0));

      foreach (tbl[i]) cyc(tbl[i], $sformatf("vec%0d", i));

      // empty program: immediate finish; start during FINISH ignored
      cyc(v(0, 1, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 1, 0), "len0_fin");
      cyc(v(0, 1, 0, 0, 0, 11'h000, 2, 11'h000, 0, 0, 0, 0), "len0_start_in_fin");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0), "len0_idle");

      // truncated load at the last program word
      cyc(v(0, 1, 0, 1, 0, 11'h040, 1, 11'h040, 0, 1, 0, 0), "trunc_issue");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 1), "trunc_err");
      cyc(v(0, 0, 1, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 1), "trunc_err_held");

      // watchdog expiry, then restart from ERROR with Done on the final cycle
      cyc(v(0, 1, 0, 1, 0, 11'h123, 1, 11'h123, 0, 1, 0, 0), "wd_restart_issue");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h123, 0, 1, 0, 0), "wd_enter_wait");
      for (int i = 1; i < 64; i++)
         cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h123, 0, 1, 0, 0), $sformatf("wd_wait%0d", i));
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 1), "wd_timeout");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 1), "wd_err_sticky");
      cyc(v(0, 1, 0, 0, 0, 11'h000, 1, 11'h123, 0, 1, 0, 0), "wd_rerun_issue");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h123, 0, 1, 0, 0), "wd_rerun_wait");
      for (int i = 1; i < 64; i++)
         cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h123, 0, 1, 0, 0), $sformatf("wd_rerun%0d", i));
      cyc(v(0, 0, 1, 0, 0, 11'h000, 0, 11'h000, 0, 0, 1, 0), "wd_done_wins");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0), "wd_idle");

      // abort by reset in WAIT of word 1; start/write while busy are dropped
      cyc(v(0, 0, 0, 1, 1, 11'h2C3, 0, 11'h000, 0, 0, 0, 0), "rst_wr1");
      cyc(v(0, 1, 0, 1, 0, 11'h1A5, 2, 11'h1A5, 0, 1, 0, 0), "rst_issue0");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h1A5, 0, 1, 0, 0), "rst_wait0");
      cyc(v(0, 0, 1, 0, 0, 11'h000, 0, 11'h2C3, 1, 1, 0, 0), "rst_issue1");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h2C3, 1, 1, 0, 0), "rst_wait1");
      cyc(v(0, 1, 0, 1, 1, 11'h555, 1, 11'h2C3, 1, 1, 0, 0), "busy_ignores");
      cyc(v(1, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0), "rst_abort");
      cyc(v(0, 1, 0, 0, 0, 11'h000, 2, 11'h1A5, 0, 1, 0, 0), "rb_issue0");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h1A5, 0, 1, 0, 0), "rb_wait0");
      cyc(v(0, 0, 1, 0, 0, 11'h000, 0, 11'h2C3, 1, 1, 0, 0), "rb_word1_kept");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h2C3, 1, 1, 0, 0), "rb_wait1");
      cyc(v(0, 0, 1, 0, 0, 11'h000, 0, 11'h000, 0, 0, 1, 0), "rb_fin");
      cyc(v(0, 0, 0, 0, 0, 11'h000, 0, 11'h000, 0, 0, 0, 0), "rb_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
